// File: rtl/lapido_defs.sv
// Shared lapido definitions: ALU function codes, flag indices and the overflow
// rule selector used between the ALU datapath and its flag logic.
package lapido_defs;

   localparam logic [5:0] FN_ADD  = 6'd0;
   localparam logic [5:0] FN_SUB  = 6'd1;
   localparam logic [5:0] FN_ASL  = 6'd2;
   localparam logic [5:0] FN_ASR  = 6'd3;
   localparam logic [5:0] FN_AND  = 6'd4;
   localparam logic [5:0] FN_NAND = 6'd5;
   localparam logic [5:0] FN_OR   = 6'd6;
   localparam logic [5:0] FN_NOR  = 6'd7;
   localparam logic [5:0] FN_XNOR = 6'd8;
   localparam logic [5:0] FN_XOR  = 6'd9;
   localparam logic [5:0] FN_NOT  = 6'd10;
   localparam logic [5:0] FN_LSL  = 6'd11;
   localparam logic [5:0] FN_LSR  = 6'd12;
   localparam logic [5:0] FN_SLT  = 6'd13;

   localparam int unsigned FL_OVERFLOW = 0;
   localparam int unsigned FL_NEG      = 1;
   localparam int unsigned FL_ZERO     = 2;
   localparam int unsigned FL_NEGZERO  = 3;
   localparam int unsigned FL_TRUE     = 4;
   localparam int unsigned NUM_FLAGS   = 5;

   // Which overflow rule applies to the current operation.
   typedef enum logic [1:0] {
      OvNone,
      OvAdd,
      OvSub,
      OvAsl
   } ov_kind_e;

endpackage

// File: rtl/alu_flags.sv
// Combinational condition-flag generation from the 32-bit ALU value and the
// operand sign bits; the carry bit is deliberately not an input.
module alu_flags
   import lapido_defs::*;
(
   input  logic [31:0]          r,
   input  ov_kind_e             ov_kind,
   input  logic [1:0]           op1_top,
   input  logic                 op2_sign,
   output logic [NUM_FLAGS-1:0] flags
);

   logic overflow;
   logic zero;

   always_comb begin
      overflow = 1'b0;
      unique case (ov_kind)
         OvAdd:   overflow = (op1_top[1] == op2_sign) && (r[31] != op1_top[1]);
         OvSub:   overflow = (op1_top[1] != op2_sign) && (r[31] != op1_top[1]);
         OvAsl:   overflow = op1_top[1] ^ op1_top[0];
         default: overflow = 1'b0;
      endcase
   end

   assign zero = (r == 32'd0);

   always_comb begin
      flags              = '0;
      flags[FL_OVERFLOW] = overflow;
      flags[FL_NEG]      = r[31];
      flags[FL_ZERO]     = zero;
      flags[FL_NEGZERO]  = r[31] | zero;
      flags[FL_TRUE]     = ~zero;
   end

endmodule

// File: rtl/alu.sv
// lapido execute-stage ALU: combinational datapath with registered result
// (bit 32 is carry/borrow) and registered condition flags.
module alu
   import lapido_defs::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [31:0]   op1,
   input  logic signed [31:0]   op2,
   input  logic [5:0]           alu_funct,
   output logic signed [32:0]   alu_res,
   output logic [NUM_FLAGS-1:0] flags
);

   logic [32:0]          res_d, res_q;
   logic [NUM_FLAGS-1:0] flags_d, flags_q;
   ov_kind_e             ov_kind;

   always_comb begin
      res_d   = '0;
      ov_kind = OvNone;
      case (alu_funct)
         FN_ADD: begin
            res_d   = {1'b0, op1} + {1'b0, op2};
            ov_kind = OvAdd;
         end
         // Bit 32 of the 33-bit difference is the unsigned borrow.
         FN_SUB: begin
            res_d   = {1'b0, op1} - {1'b0, op2};
            ov_kind = OvSub;
         end
         FN_ASL: begin
            res_d   = {op1[31], op1[30:0], 1'b0};
            ov_kind = OvAsl;
         end
         FN_ASR:  res_d = {op1[0], op1[31], op1[31:1]};
         FN_AND:  res_d = {1'b0, op1 & op2};
         FN_NAND: res_d = {1'b0, ~(op1 & op2)};
         FN_OR:   res_d = {1'b0, op1 | op2};
         FN_NOR:  res_d = {1'b0, ~(op1 | op2)};
         FN_XNOR: res_d = {1'b0, ~(op1 ^ op2)};
         FN_XOR:  res_d = {1'b0, op1 ^ op2};
         FN_NOT:  res_d = {1'b0, ~op1};
         FN_LSL:  res_d = {op1[31], op1[30:0], 1'b0};
         FN_LSR:  res_d = {op1[0], 1'b0, op1[31:1]};
         FN_SLT:  res_d = {32'd0, (op1 < op2)};
         default: res_d = '0;
      endcase
   end

   alu_flags u_alu_flags (
      .r        (res_d[31:0]),
      .ov_kind  (ov_kind),
      .op1_top  (op1[31:30]),
      .op2_sign (op2[31]),
      .flags    (flags_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign alu_res = res_q;
   assign flags   = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_alu;
   import lapido_defs::*;

   localparam longint MaxS = 64'sd2147483647;
   localparam longint MinS = -64'sd2147483648;

   logic        clk;
   logic        rst_n;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [5:0]  alu_funct;
   logic [32:0] alu_res;
   logic [4:0]  flags;

   int errors = 0;
   int checks = 0;

   logic [37:0] exp_q;
   logic        cmp_en = 1'b0;

   alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op1       (op1),
      .op2       (op2),
      .alu_funct (alu_funct),
      .alu_res   (alu_res),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: {carry, value, flags} from plain integer arithmetic.
   function automatic logic [37:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub, t;
      logic [31:0] r;
      logic        c, ov;
      logic [4:0]  fl;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r  = 32'd0;
      c  = 1'b0;
      ov = 1'b0;
      case (f)
         6'd0: begin
            t  = ua + ub;
            r  = t[31:0];
            c  = t[32];
            ov = (sa + sb > MaxS) || (sa + sb < MinS);
         end
         6'd1: begin
            t  = ua - ub;
            r  = t[31:0];
            c  = (ua < ub);
            ov = (sa - sb > MaxS) || (sa - sb < MinS);
         end
         6'd2: begin
            t  = ua * 2;
            r  = t[31:0];
            c  = (ua >= 64'd2147483648);
            ov = (sa * 2 > MaxS) || (sa * 2 < MinS);
         end
         6'd3: begin
            t = (sa - longint'({63'd0, a[0]})) / 2;
            r = t[31:0];
            c = a[0];
         end
         6'd4:  r = a & b;
         6'd5:  r = ~(a & b);
         6'd6:  r = a | b;
         6'd7:  r = ~(a | b);
         6'd8:  r = ~(a ^ b);
         6'd9:  r = a ^ b;
         6'd10: r = ~a;
         6'd11: begin
            t = ua * 2;
            r = t[31:0];
            c = (ua >= 64'd2147483648);
         end
         6'd12: begin
            t = ua / 2;
            r = t[31:0];
            c = (ua % 2 == 1);
         end
         6'd13: r = (sa < sb) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      fl              = '0;
      fl[FL_OVERFLOW] = ov;
      fl[FL_NEG]      = ($signed(r) < 0);
      fl[FL_ZERO]     = (r == 32'd0);
      fl[FL_NEGZERO]  = ($signed(r) < 0) || (r == 32'd0);
      fl[FL_TRUE]     = (r != 32'd0);
      return {c, r, fl};
   endfunction

   task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                  name, act[37:5], act[4:0], exp[37:5], exp[4:0]);
      end
   endtask

   always @(posedge clk) begin
      exp_q  <= !rst_n ? 38'd0 : model(alu_funct, op1, op2);
      cmp_en <= 1'b1;
   end

   always @(negedge clk) begin
      if (cmp_en) check("pipe", {alu_res, flags}, exp_q);
   end

   // Literal vector: pins the model and the DUT to a hand-computed value.
   task automatic vec(input string name, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [37:0] lit);
      @(negedge clk);
      alu_funct = f;
      op1       = a;
      op2       = b;
      check({name, "/model"}, model(f, a, b), lit);
      @(posedge clk);
      #1;
      check(name, {alu_res, flags}, lit);
   endtask

   initial begin
      rst_n     = 1'b0;
      alu_funct = FN_ADD;
      op1       = 32'd5;
      op2       = 32'd3;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset", {alu_res, flags}, 38'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_add", {alu_res, flags}, {1'b0, 32'd8, 5'b10000});

      vec("add_ovf",   FN_ADD,  32'h7FFFFFFF, 32'h1, {1'b0, 32'h80000000, 5'b11011});
      vec("add_carry", FN_ADD,  32'hFFFFFFFF, 32'h1, {1'b1, 32'h00000000, 5'b01100});
      vec("sub_neg",   FN_SUB,  32'd3, 32'd5,        {1'b1, 32'hFFFFFFFE, 5'b11010});
      vec("sub_zero",  FN_SUB,  32'd5, 32'd5,        {1'b0, 32'h00000000, 5'b01100});
      vec("sub_ovf",   FN_SUB,  32'h80000000, 32'h1, {1'b0, 32'h7FFFFFFF, 5'b10001});
      vec("slt_true",  FN_SLT,  32'hFFFFFFF9, 32'd2, {1'b0, 32'h00000001, 5'b10000});
      vec("slt_false", FN_SLT,  32'd2, 32'hFFFFFFF9, {1'b0, 32'h00000000, 5'b01100});
      vec("asl",       FN_ASL,  32'hC0000001, 32'h0, {1'b1, 32'h80000002, 5'b11010});
      vec("asr",       FN_ASR,  32'hC0000001, 32'h0, {1'b1, 32'hE0000000, 5'b11010});
      vec("lsl",       FN_LSL,  32'hC0000001, 32'h0, {1'b1, 32'h80000002, 5'b11010});
      vec("lsr",       FN_LSR,  32'hC0000001, 32'h0, {1'b1, 32'h60000000, 5'b10000});
      vec("asl_ovf",   FN_ASL,  32'h40000000, 32'h0, {1'b0, 32'h80000000, 5'b11011});
      vec("and",  FN_AND,  32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'hF000F000, 5'b11010});
      vec("nand", FN_NAND, 32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'h0FFF0FFF, 5'b10000});
      vec("or",   FN_OR,   32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'hFFF0FFF0, 5'b11010});
      vec("nor",  FN_NOR,  32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'h000F000F, 5'b10000});
      vec("xor",  FN_XOR,  32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'h0FF00FF0, 5'b10000});
      vec("xnor", FN_XNOR, 32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'hF00FF00F, 5'b11010});
      vec("not",  FN_NOT,  32'hF0F0F0F0, 32'hFF00FF00, {1'b0, 32'h0F0F0F0F, 5'b10000});
      vec("unlisted", 6'd63, 32'h12345678, 32'h9ABCDEF0, {1'b0, 32'h00000000, 5'b01100});

      // Back-to-back random vectors, covered by the per-cycle pipe check.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         alu_funct = 6'($urandom_range(0, 15));
         op1       = $urandom;
         op2       = $urandom;
      end
      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
